// File: rtl/trigger_gen_prog.sv
// trigger_gen_prog: programmable periodic / one-shot trigger generator.
//
// A period counter runs in RUN and produces a "finished" event every P
// cycles (P = active period, 0 treated as 1). Each finished event loads the
// pulse counter with the latched width W (0 treated as 1). The registered
// trigger is high while that counter is non-zero. In one-shot mode the first
// finished event moves to TAIL. TAIL waits for the pulse to expire and then
// returns to IDLE.
//
// The period is double-buffered. period_ld writes the shadow register. The
// active period copies the shadow while IDLE, and in RUN it copies it only
// at wrap.
//
// Optional feature: define TRIG_GEN_TCNT_EN to build a saturating counter of
// finished events on trig_cnt. Without it, trig_cnt is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   nul        active-low synchronous clear of period/pulse counters
//   en         enable; low forces IDLE
//   start      start request, honoured in IDLE only
//   oneshot    mode latched with start (1 = single trigger)
//   period     period value in cycles
//   period_ld  load period into the shadow register
//   pulse_w    trigger high time, latched with start
//   trigger    registered trigger pulse
//   busy       state != IDLE
//   trig_cnt   saturating trigger event count (0 when feature absent)
module trigger_gen_prog #(
    parameter int CNT_W      = 8,
    parameter int PW_W       = 4,
    parameter int DEF_PERIOD = 2,
    parameter int TCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nul,
    input  logic              en,
    input  logic              start,
    input  logic              oneshot,
    input  logic [CNT_W-1:0]  period,
    input  logic              period_ld,
    input  logic [PW_W-1:0]   pulse_w,
    output logic              trigger,
    output logic              busy,
    output logic [TCNT_W-1:0] trig_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  shadow_q, shadow_d;
    logic [CNT_W-1:0]  active_q, active_d;
    logic [PW_W-1:0]   pc_q, pc_d;
    logic [PW_W-1:0]   width_q, width_d;
    logic              mode_q, mode_d;
    logic              trig_q, trig_d;
    logic [CNT_W-1:0]  p_eff;
    logic [PW_W-1:0]   w_eff;
    logic              fin_evt;

    assign p_eff = (active_q == '0) ? CNT_W'(1) : active_q;
    assign w_eff = (width_q == '0) ? PW_W'(1) : width_q;

    assign trigger = trig_q;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        shadow_d = shadow_q;
        active_d = active_q;
        mode_d   = mode_q;
        width_d  = width_q;
        fin_evt  = 1'b0;

        if (!nul) begin
            // The clear only restarts timing. State and both periods are kept.
            cnt_d = '0;
            pc_d  = '0;
        end else begin
            if (period_ld) shadow_d = period;
            // While IDLE, the active period tracks the shadow one edge later.
            if (state_q == IDLE) active_d = shadow_q;

            if (!en) begin
                state_d = IDLE;
                cnt_d   = '0;
                pc_d    = '0;
            end else begin
                if (pc_q != '0) pc_d = pc_q - PW_W'(1);
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_d = RUN;
                            cnt_d   = '0;
                            mode_d  = oneshot;
                            width_d = pulse_w;
                        end
                    end
                    RUN: begin
                        if (cnt_q == p_eff - CNT_W'(1)) begin
                            fin_evt = 1'b1;
                            cnt_d   = '0;
                            pc_d    = w_eff;
                            // Wrap is the only point where the period may
                            // change. A load on this same edge wins.
                            active_d = period_ld ? period : shadow_q;
                            if (mode_q) state_d = TAIL;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    TAIL: begin
                        if (pc_d == '0) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        trig_d = (pc_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pc_q     <= '0;
            shadow_q <= DEF_P;
            active_q <= DEF_P;
            mode_q   <= 1'b0;
            width_q  <= PW_W'(1);
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            mode_q   <= mode_d;
            width_q  <= width_d;
            trig_q   <= trig_d;
        end
    end

`ifdef TRIG_GEN_TCNT_EN
    logic [TCNT_W-1:0] tcnt_q;

    // Finished events only occur with nul and en high, so this counter
    // is naturally unaffected by either.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
        end else if (fin_evt && (tcnt_q != '1)) begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
        end
    end

    assign trig_cnt = tcnt_q;
`else
    logic tcnt_unused;
    assign tcnt_unused = fin_evt;
    assign trig_cnt    = '0;
`endif

endmodule

// File: doc/trigger_gen_prog.md
Name: trigger_gen_prog

Overview:
Programmable periodic/one-shot trigger generator; next generation of the fixed divide-by-N trigger block.
Adds run-time period load, start/enable control, one-shot mode, programmable pulse width and a busy flag.
Sits between control registers and timing consumers (ADC sample strobes, PWM frame starts).
Keeps the active-low synchronous counter clear `nul` of the previous generation.

Parameters:
CNT_W, 8, width of period counter and period input
PW_W, 4, width of pulse-width input
DEF_PERIOD, 2, active and shadow period after reset (1..2^CNT_W-1)
TCNT_W, 16, width of trigger event counter (optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
nul  in  1  active-low synchronous clear of counters/pulse
en  in  1  enable; low forces IDLE
start  in  1  start request, sampled in IDLE only
oneshot  in  1  1 = single trigger then stop, 0 = periodic; sampled with start
period  in  CNT_W  period value in cycles
period_ld  in  1  load `period` into shadow register
pulse_w  in  PW_W  trigger high time in cycles, sampled with start
trigger  out  1  registered trigger pulse
busy  out  1  high when state != IDLE
trig_cnt  out  TCNT_W  saturating count of trigger events

Behaviour:
- Priority per edge: rst > nul low > en low > normal operation.
- Reset (synchronous, active-high): state IDLE, cnt=0, pulse counter=0, trigger=0, busy=0, trig_cnt=0, shadow=active=DEF_PERIOD, latched mode=periodic, latched width=1.
- Effective period: P = active period, with 0 treated as 1. Effective width: W = latched pulse_w, with 0 treated as 1.
- period_ld: shadow <= period.
  - In IDLE, the active period follows the shadow on the next edge.
  - In RUN, the active period updates only at wrap, the edge where finished is used.
  - If period_ld coincides with wrap, the new value is the one taken.
- States: IDLE, RUN, TAIL.
- IDLE: trigger held by pulse logic only. `en & start` -> RUN, cnt <= 0, latch oneshot and pulse_w.
- RUN: finished = (cnt == P-1).
  - If finished: cnt <= 0, pulse counter <= W, trigger <= 1.
  - Otherwise: cnt <= cnt+1.
  - Oneshot and finished: go to TAIL.
- TAIL: hold until the pulse counter expires, then go to IDLE. start is ignored.
- Pulse logic:
  - While the pulse counter > 0: trigger=1 and the counter decrements each cycle.
  - When it reaches 0: trigger=0.
  - A new finished event reloads the counter to W.
  - If W >= P in periodic mode, trigger stays continuously high.
- Latency: start sampled at edge E0 -> first trigger high after edge E(P), i.e. P cycles later; in periodic mode, rising edges are spaced exactly P cycles apart.
- nul low: cnt <= 0, pulse counter <= 0, trigger <= 0. State, periods and trig_cnt unchanged. Counting resumes from 0 on the next edge with nul high.
- en low (any state): state <= IDLE, cnt <= 0, pulse counter <= 0, trigger <= 0 on that edge.
- busy is combinational from state; deasserts on the edge TAIL -> IDLE.
- cnt arithmetic: CNT_W bits, never exceeds P-1, no wrap-around overflow possible.
- Reset mid-operation: everything returns to reset values on that edge, including the shadow period.

Optional Feature:
Macro TRIG_GEN_TCNT_EN.
- Defined: trig_cnt increments by 1 on every finished event, saturates at 2^TCNT_W-1, is cleared only by rst, and is unaffected by nul and en.
- Not defined: counter logic is absent and trig_cnt is driven constant 0. The port list is identical in both builds.

Test Plan:
- Reset: assert rst 2 cycles with start=1 -> trigger=0, busy=0, trig_cnt=0; periodic start without period_ld -> triggers every 2 cycles (DEF_PERIOD).
- Periodic: period_ld with 4, pulse_w=1, start at E0 -> trigger high after E4, E8, E12, each for 1 cycle; busy=1 throughout.
- One-shot: period 3, pulse_w=2, oneshot=1, start at E0 -> trigger high after E3 and E4, low after E5, busy low after E5; a second start during TAIL is ignored.
- Period change: running with P=4, period_ld with 6 at cnt=1 -> the current period still ends at 4 cycles, all subsequent gaps are 6 cycles.
- nul/en: nul low 1 cycle at cnt=2 (P=5) -> next trigger 5 cycles after nul released, state still RUN. Drop en -> busy=0 and trigger=0 the next cycle.
- Width/saturation: P=3, pulse_w=5 -> trigger constant 1 after the first event. With TRIG_GEN_TCNT_EN and TCNT_W=4: 20 events -> trig_cnt sticks at 15.
